// File: rtl/spi_slave_ctrl_if.sv
// Control-side bundle between the SPI slave sequencer and its datapath:
// synchronised sclk edges, cs and mosi in; datapath enables out.
interface spi_slave_ctrl_if;
  logic positiveedge_sclk;
  logic negativeedge_sclk;
  logic cs;
  logic mosi;
  logic miso_buf;
  logic addr_we;
  logic sr_we;
  logic dm_we;
  logic addr_inc;

  modport master (
    output positiveedge_sclk, negativeedge_sclk, cs, mosi,
    input  miso_buf, addr_we, sr_we, dm_we, addr_inc
  );

  modport slave (
    input  positiveedge_sclk, negativeedge_sclk, cs, mosi,
    output miso_buf, addr_we, sr_we, dm_we, addr_inc
  );
endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI slave transaction sequencer: address capture, R/W decision, shift-register load, memory commit.
// Define SPI_SLAVE_CTRL_BURST_EN to build the NEXT state (address auto-increment bursts).
module spi_slave_ctrl #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_slave_ctrl_if.slave  bus
);

  localparam int unsigned MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(MAX_W + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_LATCH,
    S_RW,
    S_READ_LOAD,
    S_READ_SHIFT,
    S_WRITE_SHIFT,
    S_WRITE_COMMIT
`ifdef SPI_SLAVE_CTRL_BURST_EN
    , S_NEXT
`endif
  } state_e;

`ifdef SPI_SLAVE_CTRL_BURST_EN
  localparam state_e EOW_STATE = S_NEXT;
`else
  localparam state_e EOW_STATE = S_ADDR;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               rw_q, rw_d;
  logic               miso_buf_q, miso_buf_d;
  logic               addr_we_q, addr_we_d;
  logic               sr_we_q, sr_we_d;
  logic               dm_we_q, dm_we_d;
`ifdef SPI_SLAVE_CTRL_BURST_EN
  logic               addr_inc_q, addr_inc_d;
`endif

  // Falling sclk edges only matter to the shift-register path.
  logic unused_negedge;
  assign unused_negedge = bus.negativeedge_sclk;

  // Next state, bit counter and R/W flag; cs high overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    cnt_inc = cnt_q + CNT_W'(1);
    if (bus.cs) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      rw_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_ADDR;
          cnt_d   = '0;
          rw_d    = 1'b0;
        end
        S_ADDR: begin
          if (bus.positiveedge_sclk) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(ADDR_WIDTH)) begin
              state_d = S_ADDR_LATCH;
              cnt_d   = '0;
            end
          end
        end
        S_ADDR_LATCH: state_d = S_RW;
        S_RW: begin
          if (bus.positiveedge_sclk) begin
            rw_d    = bus.mosi;
            state_d = bus.mosi ? S_READ_LOAD : S_WRITE_SHIFT;
            cnt_d   = '0;
          end
        end
        S_READ_LOAD: state_d = S_READ_SHIFT;
        S_READ_SHIFT: begin
          if (bus.positiveedge_sclk) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DATA_WIDTH)) begin
              state_d = EOW_STATE;
              cnt_d   = '0;
            end
          end
        end
        S_WRITE_SHIFT: begin
          if (bus.positiveedge_sclk) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DATA_WIDTH)) begin
              state_d = S_WRITE_COMMIT;
              cnt_d   = '0;
            end
          end
        end
        S_WRITE_COMMIT: begin
          state_d = EOW_STATE;
          cnt_d   = '0;
        end
`ifdef SPI_SLAVE_CTRL_BURST_EN
        S_NEXT: begin
          state_d = rw_q ? S_READ_LOAD : S_WRITE_SHIFT;
          cnt_d   = '0;
        end
`endif
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are a pure decode of the state, registered alongside it.
  always_comb begin
    miso_buf_d = (state_d == S_READ_LOAD) || (state_d == S_READ_SHIFT);
    addr_we_d  = (state_d == S_ADDR_LATCH);
    sr_we_d    = (state_d == S_READ_LOAD);
    dm_we_d    = (state_d == S_WRITE_COMMIT);
`ifdef SPI_SLAVE_CTRL_BURST_EN
    addr_inc_d = (state_d == S_NEXT);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rw_q       <= 1'b0;
      miso_buf_q <= 1'b0;
      addr_we_q  <= 1'b0;
      sr_we_q    <= 1'b0;
      dm_we_q    <= 1'b0;
`ifdef SPI_SLAVE_CTRL_BURST_EN
      addr_inc_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      miso_buf_q <= miso_buf_d;
      addr_we_q  <= addr_we_d;
      sr_we_q    <= sr_we_d;
      dm_we_q    <= dm_we_d;
`ifdef SPI_SLAVE_CTRL_BURST_EN
      addr_inc_q <= addr_inc_d;
`endif
    end
  end

  assign bus.miso_buf = miso_buf_q;
  assign bus.addr_we  = addr_we_q;
  assign bus.sr_we    = sr_we_q;
  assign bus.dm_we    = dm_we_q;
`ifdef SPI_SLAVE_CTRL_BURST_EN
  assign bus.addr_inc = addr_inc_q;
`else
  assign bus.addr_inc = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: 7/8-bit and 10/16-bit instances share one stimulus stream.
module tb_spi_slave_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic pos, neg, cs, mosi;

  always #5 clk = ~clk;

  spi_slave_ctrl_if b1 ();
  spi_slave_ctrl_if b2 ();

  assign b1.positiveedge_sclk = pos;
  assign b1.negativeedge_sclk = neg;
  assign b1.cs                = cs;
  assign b1.mosi              = mosi;
  assign b2.positiveedge_sclk = pos;
  assign b2.negativeedge_sclk = neg;
  assign b2.cs                = cs;
  assign b2.mosi              = mosi;

  spi_slave_ctrl #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  spi_slave_ctrl #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2)
  );

  // {miso_buf, addr_we, sr_we, dm_we, addr_inc}
  logic [4:0] o1, o2;
  assign o1 = {b1.miso_buf, b1.addr_we, b1.sr_we, b1.dm_we, b1.addr_inc};
  assign o2 = {b2.miso_buf, b2.addr_we, b2.sr_we, b2.dm_we, b2.addr_inc};

  int n_assert = 0;
  int n_fail   = 0;

  // Per-cycle high counts of dut1 outputs, sampled mid-cycle.
  int n_miso = 0, n_aw = 0, n_sr = 0, n_dm = 0, n_inc = 0;
  always @(negedge clk) begin
    if (b1.miso_buf === 1'b1) n_miso++;
    if (b1.addr_we  === 1'b1) n_aw++;
    if (b1.sr_we    === 1'b1) n_sr++;
    if (b1.dm_we    === 1'b1) n_dm++;
    if (b1.addr_inc === 1'b1) n_inc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hi(input logic m);
    pos  = 1'b1;
    neg  = 1'b0;
    mosi = m;
    step();
  endtask

  task automatic lo();
    pos = 1'b0;
    neg = 1'b1;
    step();
    neg = 1'b0;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      hi(v[i]);
      lo();
    end
  endtask

  int m0, a0, s0, d0, i0;

  task automatic snap();
    m0 = n_miso; a0 = n_aw; s0 = n_sr; d0 = n_dm; i0 = n_inc;
  endtask

  logic [31:0] addr_v, data_v;

  initial begin
    rst_n = 1'b0; cs = 1'b1; pos = 1'b0; neg = 1'b0; mosi = 1'b0;
    #2 chk("reset_outs", 32'(o1), 32'h0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("idle_cs_high", 32'(o1), 32'h0);

    // Write 0x2A to 0x15
    addr_v = 32'h15; data_v = 32'h2A;
    cs = 1'b0; step();
    chk("wr_enter_addr", 32'(o1), 32'h0);
    snap();
    for (int i = 6; i >= 0; i--) begin
      hi(addr_v[i]);
      chk("wr_addr_we", 32'(b1.addr_we), (i == 0) ? 32'h1 : 32'h0);
      lo();
    end
    chk("wr_addr_we_width", 32'(o1), 32'h0);
    hi(1'b0);
    chk("wr_rw_no_load", 32'(o1), 32'h0);
    lo();
    for (int i = 7; i >= 0; i--) begin
      pos = 1'b1; neg = (i == 3); mosi = data_v[i];
      step();
      chk("wr_dm_we", 32'(b1.dm_we), (i == 0) ? 32'h1 : 32'h0);
      lo();
    end
    chk("wr_back_to_addr", 32'(o1), 32'h0);
    chk("wr_dm_count", 32'(n_dm - d0), 32'd1);
    chk("wr_aw_count", 32'(n_aw - a0), 32'd1);
    chk("wr_miso_never", 32'(n_miso - m0), 32'd0);

    // Read 0x15, continuing without cs toggle
    snap();
    send(addr_v, 7);
    hi(1'b1);
    chk("rd_load", 32'(o1), 32'h14);
    lo();
    chk("rd_shift", 32'(o1), 32'h10);
    for (int i = 7; i >= 0; i--) begin
      hi(1'b0);
      chk("rd_miso", 32'(o1), (i == 0) ? 32'h00 : 32'h10);
      lo();
    end
    chk("rd_sr_count", 32'(n_sr - s0), 32'd1);
    chk("rd_miso_cycles", 32'(n_miso - m0), 32'd16);
    chk("rd_aw_count", 32'(n_aw - a0), 32'd1);

    // Write aborted after 5 data bits, then a fresh transaction
    snap();
    send(addr_v, 7);
    send(32'h0, 1);
    send(32'h1F, 5);
    cs = 1'b1; step();
    chk("abort_idle", 32'(o1), 32'h0);
    send(32'h7, 3);
    chk("abort_no_dm", 32'(n_dm - d0), 32'd0);
    cs = 1'b0; step();
    snap();
    send(32'h15, 7);
    send(32'h0, 1);
    send(32'h2A, 8);
    chk("fresh_dm_count", 32'(n_dm - d0), 32'd1);
    chk("fresh_aw_count", 32'(n_aw - a0), 32'd1);

    // Asynchronous reset in the middle of a read word
    send(32'h15, 7);
    send(32'h1, 1);
    send(32'h5, 3);
    chk("pre_reset_miso", 32'(o1), 32'h10);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 32'(o1), 32'h0);
    cs = 1'b1;
    #1 rst_n = 1'b1;
    step(); step();
    chk("post_reset_idle", 32'(o1), 32'h0);
    snap();
    send(32'h7F, 7);
    chk("post_reset_no_aw", 32'(n_aw - a0), 32'd0);

    // 10-bit address / 16-bit data write on dut2
    cs = 1'b0; step();
    chk("w16_enter", 32'(o2), 32'h0);
    for (int i = 9; i >= 0; i--) begin
      hi(1'b1);
      chk("w16_addr_we", 32'(b2.addr_we), (i == 0) ? 32'h1 : 32'h0);
      lo();
    end
    hi(1'b0);
    chk("w16_rw", 32'(o2), 32'h0);
    lo();
    for (int i = 15; i >= 0; i--) begin
      hi(i[0]);
      chk("w16_dm_we", 32'(b2.dm_we), (i == 0) ? 32'h1 : 32'h0);
      chk("w16_no_miso", 32'(b2.miso_buf), 32'h0);
      lo();
    end
    chk("w16_done", 32'(o2), 32'h0);

    // Multi-word read: burst continues, otherwise the next word is an address
    cs = 1'b1; step();
    cs = 1'b0; step();
    snap();
    send(32'h15, 7);
    send(32'h1, 1);
`ifdef SPI_SLAVE_CTRL_BURST_EN
    for (int w = 0; w < 2; w++) begin
      send(32'hA, 7);
      hi(1'b0);
      chk("burst_next", 32'(o1), 32'h01);
      lo();
      chk("burst_reload", 32'(o1), 32'h14);
      step();
    end
    send(32'h3F, 7);
    pos = 1'b1; cs = 1'b1; step();
    pos = 1'b0; step();
    chk("burst_end_idle", 32'(o1), 32'h0);
    chk("burst_sr_count", 32'(n_sr - s0), 32'd3);
    chk("burst_inc_count", 32'(n_inc - i0), 32'd2);
    chk("burst_aw_count", 32'(n_aw - a0), 32'd1);
`else
    send(32'hA5, 8);
    chk("nb_word_end", 32'(o1), 32'h0);
    send(32'h33, 7);
    chk("nb_second_is_addr", 32'(n_aw - a0), 32'd2);
    chk("nb_no_inc", 32'(n_inc - i0), 32'd0);
    chk("nb_sr_count", 32'(n_sr - s0), 32'd1);
    chk("nb_in_rw", 32'(o1), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_ctrl.md
# spi_slave_ctrl

Parametrised SPI slave transaction controller: it sequences address capture, the read/write decision, shift-register load and data-memory commit for the SPI memory peripheral. It sits between the sclk edge detectors / cs synchroniser and the address latch, shift register, data memory and MISO tri-state buffer. It generalises the fixed 7-bit-address / 8-bit-data sequencer to arbitrary widths using a bit counter instead of per-bit states. It adds an async reset, a read-only MISO enable and an optional burst (auto-increment) mode.

## Interface
- ADDR_WIDTH, 7, address bits per transaction (≥1)
- DATA_WIDTH, 8, data bits per word (≥1)

- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- positiveedge_sclk  in  1  one-clk pulse per sclk rising edge (synchronised)
- negativeedge_sclk  in  1  one-clk pulse per sclk falling edge (synchronised)
- cs  in  1  chip select, active low (synchronised)
- mosi  in  1  serial data in (synchronised)
- miso_buf  out  1  MISO tri-state enable
- addr_we  out  1  address latch write enable
- sr_we  out  1  shift-register parallel-load enable
- dm_we  out  1  data memory write enable
- addr_inc  out  1  address latch increment pulse (0 unless burst compiled in)

## Operation
- Moore machine: outputs are decoded from the state register only. Internal bit counter is $clog2(max(ADDR_WIDTH,DATA_WIDTH)+1) bits wide.
- States and transitions:
  - IDLE: cs=0 → ADDR, counter=0.
  - ADDR: each positiveedge_sclk increments the counter. On the ADDR_WIDTH-th edge → ADDR_LATCH.
  - ADDR_LATCH: exactly 1 clk, addr_we=1 → RW.
  - RW: on positiveedge_sclk, sample mosi. mosi=1 → READ_LOAD; mosi=0 → WRITE_SHIFT. Counter=0 in both cases.
  - READ_LOAD: exactly 1 clk, sr_we=1, miso_buf=1 → READ_SHIFT.
  - READ_SHIFT: miso_buf=1. Count positiveedge_sclk; on the DATA_WIDTH-th edge → end-of-word.
  - WRITE_SHIFT: count positiveedge_sclk; on the DATA_WIDTH-th edge → WRITE_COMMIT.
  - WRITE_COMMIT: exactly 1 clk, dm_we=1 → end-of-word.
  - End-of-word without burst: → ADDR, counter=0 (next transaction without cs toggle).
  - NEXT (burst only): exactly 1 clk, addr_inc=1. Then → READ_LOAD if the transaction was a read, else → WRITE_SHIFT; counter=0.
- All outputs are 0 in every state except as listed above. miso_buf is never 1 during address, RW or write phases.
- negativeedge_sclk is ignored by the state machine (it is an input for the shift-register path only). If both edge pulses are high in one clk, only positiveedge_sclk is acted on.
- The R/W flag is held in a register set in RW and cleared in IDLE.

## Timing
- Reset (rst_n=0, async): state=IDLE, counter=0, R/W flag=0, all outputs 0 immediately. Release is synchronous to the next clk.
- cs=1 sampled at any clk edge in any state: IDLE on that edge, outputs 0 the same cycle. An abort mid-WRITE_SHIFT never produces dm_we. An abort during ADDR_LATCH/READ_LOAD/WRITE_COMMIT/NEXT truncates that pulse to its current cycle.
- Latencies:
  - ADDR_WIDTH-th address posedge pulse → addr_we high on the next clk cycle, for 1 cycle.
  - R/W posedge → sr_we high on the next cycle.
  - DATA_WIDTH-th write posedge → dm_we high on the next cycle.
  - Burst: dm_we is followed by addr_inc in the next cycle. For reads, addr_inc is followed by sr_we in the next cycle, which gives the memory one cycle of read latency.
- Pulses addr_we/sr_we/dm_we/addr_inc are each exactly one clk wide per occurrence.

## Configuration
- SPI_SLAVE_CTRL_BURST_EN defined:
  - NEXT state exists. After each data word the controller auto-increments the address and continues in the same direction until cs=1.
  - The address wraps modulo 2^ADDR_WIDTH; the wrap is owned by the latch.
- Undefined:
  - NEXT is not built and addr_inc is tied 0.
  - After each word the controller returns to ADDR.

## Test plan
- Reset mid-READ_SHIFT (rst_n low between clk edges): all outputs 0 without waiting for clk; after release with cs=1, state stays IDLE.
- ADDR_WIDTH=7, DATA_WIDTH=8, write 0x2A to address 0x15 (7 addr posedges, mosi=0 at the 8th, 8 data posedges): addr_we is one pulse after posedge 7; dm_we is one pulse after data posedge 8; miso_buf=0 throughout.
- Same widths, read address 0x15 (mosi=1 at the R/W posedge): sr_we pulses 1 clk after the R/W posedge; miso_buf=1 from READ_LOAD through the 8th data posedge, then 0 in ADDR.
- Write aborted by cs=1 after 5 data posedges: no dm_we; IDLE next clk; a fresh transaction then completes normally.
- ADDR_WIDTH=10, DATA_WIDTH=16 write: addr_we after exactly 10 posedges; dm_we after exactly 16 data posedges.
- With SPI_SLAVE_CTRL_BURST_EN, 3-word read burst: sr_we ×3, addr_inc ×2 each followed by sr_we next cycle, single addr_we. Without the macro, addr_inc stays 0 and the 2nd word is treated as an address.
